// File: rtl/wb_evc_pkg.sv
// Shared definitions for the Wishbone event counter array: register offsets,
// CTRL/STATUS bit positions, FSM states and a byte-lane merge helper.
package wb_evc_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_WINDOW = 8'h08;
    localparam logic [7:0] OFF_COUNT0 = 8'h10;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_DONE
    } evc_state_e;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = wr_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_event_counter_array_if.sv
// Wishbone slave bus bundle for the event counter array.
interface wb_event_counter_array_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/evc_channel.sv
// One event channel: 2-flop synchroniser, rising-edge detect and a
// saturating counter that flags an edge arriving while already at all-ones.
module evc_channel #(
    parameter int CNT_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ev_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_det;

    assign edge_det = sync_q[1] & ~prev_q;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        sat_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && edge_det) begin
            if (&cnt_q) sat_o = 1'b1;
            else        cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], ev_i};
            prev_q <= sync_q[1];
            cnt_q  <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/wb_event_counter_array.sv
// Wishbone slave that counts rising edges on NCH asynchronous inputs over a
// programmable window; raises irq on completion and releases outputs when inactive.
module wb_event_counter_array
    import wb_evc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NCH       = 4,
    parameter int          CNT_W     = 24,
    parameter int          WIN_W     = 24,
    parameter bit          TRISTATE  = 1'b1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   active,
    wb_event_counter_array_if.slave wbs,
    input  logic [NCH-1:0]         ev_i,
    output logic                   irq
);

    // Reset asserts immediately, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) rst_sync_q <= '0;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic             ack_q;
    logic [31:0]      dat_q;
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [WIN_W-1:0] window_q, window_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    evc_state_e       state_q, state_d;

    logic [NCH-1:0][CNT_W-1:0] count;
    logic [NCH-1:0]            sat;
    logic                      count_en, count_clr, done_set;

    // Bus decode; a request is blocked while the previous ack is still high.
    logic       hit, req, wr, rd;
    logic [7:0] off;
    logic       wr_ctrl, wr_status, wr_window;
    logic       start_wr, abort_wr;
    logic [31:0] win_merged, rd_data;

    assign hit       = wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign req       = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~ack_q;
    assign wr        = req & wbs.wbs_we_i;
    assign rd        = req & ~wbs.wbs_we_i;
    assign off       = wbs.wbs_adr_i[7:0];
    assign wr_ctrl   = wr && (off == OFF_CTRL)   && wbs.wbs_sel_i[0];
    assign wr_status = wr && (off == OFF_STATUS) && wbs.wbs_sel_i[0];
    assign wr_window = wr && (off == OFF_WINDOW);
    assign start_wr  = wr_ctrl && wbs.wbs_dat_i[CTRL_START];
    assign abort_wr  = wr_ctrl && wbs.wbs_dat_i[CTRL_ABORT];
    assign win_merged = apply_sel(32'(window_q), wbs.wbs_dat_i, wbs.wbs_sel_i);

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en_q;
            OFF_STATUS: begin
                rd_data[ST_BUSY] = (state_q != S_IDLE);
                rd_data[ST_DONE] = done_q;
                rd_data[ST_OVF]  = ovf_q;
                rd_data[15:8]    = 8'(NCH);
            end
            OFF_WINDOW: rd_data = 32'(window_q);
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (off == OFF_COUNT0 + 8'(4 * i)) rd_data = 32'(count[i]);
                end
            end
        endcase
    end

    // Measurement FSM; an abort overrides whatever the current state would do.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        count_en  = 1'b0;
        count_clr = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            S_IDLE: if (start_wr) state_d = S_ARM;
            S_ARM: begin
                count_clr = 1'b1;
                timer_d   = (window_q == '0) ? WIN_W'(1) : window_q;
                state_d   = S_COUNT;
            end
            S_COUNT: begin
                count_en = 1'b1;
                timer_d  = timer_q - WIN_W'(1);
                if (timer_q == WIN_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                done_set = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_wr) begin
            state_d   = S_IDLE;
            timer_d   = timer_q;
            count_en  = 1'b0;
            count_clr = 1'b0;
            done_set  = 1'b0;
        end
    end

    always_comb begin
        irq_en_d = irq_en_q;
        window_d = window_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        if (wr_ctrl)   irq_en_d = wbs.wbs_dat_i[CTRL_IRQ_EN];
        if (wr_window) window_d = win_merged[WIN_W-1:0];
        if (wr_status && wbs.wbs_dat_i[ST_DONE]) done_d = 1'b0;
        if (wr_status && wbs.wbs_dat_i[ST_OVF])  ovf_d  = 1'b0;
        if (count_clr) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end
        if (|sat)     ovf_d  = 1'b1;
        if (done_set) done_d = 1'b1;
    end

    // NOTE: every register here is a single flop, so all of them take the
    // reset value; there is no storage array that would need clearing.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            window_q <= '0;
            timer_q  <= '0;
            state_q  <= S_IDLE;
        end else begin
            ack_q    <= req;
            dat_q    <= rd ? rd_data : '0;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            window_q <= window_d;
            timer_q  <= timer_d;
            state_q  <= state_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        evc_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_i   (wb_clk_i),
            .rst_ni  (rst_n),
            .ev_i    (ev_i[g]),
            .en_i    (count_en),
            .clr_i   (count_clr),
            .count_o (count[g]),
            .sat_o   (sat[g])
        );
    end

    if (TRISTATE) begin : g_release_z
        assign wbs.wbs_ack_o = active ? ack_q : 1'bz;
        assign wbs.wbs_dat_o = active ? dat_q : 'z;
        assign irq           = active ? (done_q & irq_en_q) : 1'bz;
    end else begin : g_release_0
        assign wbs.wbs_ack_o = active & ack_q;
        assign wbs.wbs_dat_o = active ? dat_q : '0;
        assign irq           = active & done_q & irq_en_q;
    end

endmodule

// File: tb/tb_wb_event_counter_array.sv
// Scoreboard bench for wb_event_counter_array: expected read data is queued
// at issue time and checked by a monitor when the ack appears.
module tb_wb_event_counter_array;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int NCH = 4;
    localparam int CNT_W = 8;
    localparam int WIN_W = 16;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           active = 1'b1;
    logic [NCH-1:0] ev = '0;
    logic           irq;

    wb_event_counter_array_if bus ();

    wb_event_counter_array #(
        .BASE_ADDR (BASE),
        .NCH       (NCH),
        .CNT_W     (CNT_W),
        .WIN_W     (WIN_W),
        .TRISTATE  (1'b0)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .active    (active),
        .wbs       (bus.slave),
        .ev_i      (ev),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        bit          is_rd;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  per [NCH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] lo, input logic [31:0] hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h..0x%08h", name, got, lo, hi);
        end
    endtask

    // Square-wave event sources; period 0 holds the input low.
    initial begin
        int tick = 0;
        for (int c = 0; c < NCH; c++) per[c] = 0;
        forever begin
            @(posedge clk);
            #1;
            tick++;
            for (int c = 0; c < NCH; c++)
                ev[c] = (per[c] == 0) ? 1'b0 : (((tick / (per[c] / 2)) % 2) != 0);
        end
    end

    // Monitor: every visible ack pops one expectation.
    initial begin
        sb_t e;
        bit prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin
                check("ack_1cycle", {31'b0, prev_ack}, 0, 0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack, required none");
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_rd) check(e.name, bus.wbs_dat_o, e.lo, e.hi);
                end
            end
            prev_ack = bus.wbs_ack_o;
        end
    end

    task automatic xfer(input logic [7:0] off, input bit we, input logic [31:0] wdat,
                        input logic [3:0] sel, input string name,
                        input logic [31:0] lo, input logic [31:0] hi);
        sb_t e;
        bit  seen = 1'b0;
        e = '{name: name, lo: lo, hi: hi, is_rd: !we};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.wbs_adr_i = BASE | 32'(off);
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = wdat;
        bus.wbs_sel_i = sel;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.wbs_ack_o;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ack_timeout %s: got no ack in 10 cycles, required ack", name);
            void'(sb_q.pop_back());
        end
        @(posedge clk);
        #1;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel = 4'hF);
        xfer(off, 1'b1, d, sel, "write", 0, 0);
    endtask

    task automatic rd(input logic [7:0] off, input string name, input logic [31:0] lo,
                      input logic [31:0] hi);
        xfer(off, 1'b0, '0, 4'hF, name, lo, hi);
    endtask

    // Access while inactive: completes internally, must stay invisible.
    task automatic quiet_xfer(input logic [7:0] off, input bit we, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.wbs_adr_i = BASE | 32'(off);
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = d;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        @(posedge clk);
        #1;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(negedge clk);
        check("inactive_ack", {31'b0, bus.wbs_ack_o}, 0, 0);
        check("inactive_dat", bus.wbs_dat_o, 0, 0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(posedge clk);
        #1;
    endtask

    // Edges seen in a w-cycle window of a square wave with period p.
    task automatic exp_range(input int w, input int p, input int tol,
                             output logic [31:0] lo, output logic [31:0] hi);
        int n;
        if (p == 0) begin
            lo = 0;
            hi = 0;
        end else begin
            n  = w / p;
            lo = 32'((n - tol < 0) ? 0 : ((n - tol > CMAX) ? CMAX : n - tol));
            hi = 32'((n + tol > CMAX) ? CMAX : n + tol);
        end
    endtask

    task automatic start_window(input int w, output int s);
        wr(8'h08, 32'(w));
        wr(8'h00, 32'h5);
        s = cyc;
    endtask

    task automatic read_counts(input int w, input string tag);
        logic [31:0] lo, hi;
        for (int c = 0; c < NCH; c++) begin
            exp_range(w, per[c], 1, lo, hi);
            rd(8'h10 + 8'(4 * c), $sformatf("%s_count%0d", tag, c), lo, hi);
        end
    endtask

    initial begin
        int s, a, w;
        logic [31:0] lo, hi;
        int plist [7] = '{0, 2, 4, 6, 8, 10, 12};

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = '0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'b0, bus.wbs_ack_o}, 0, 0);
        check("rst_dat", bus.wbs_dat_o, 0, 0);
        check("rst_irq", {31'b0, irq}, 0, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        rd(8'h04, "rst_status", 32'h400, 32'h400);
        rd(8'h00, "rst_ctrl", 0, 0);
        rd(8'h08, "rst_window", 0, 0);
        read_counts(0, "rst");
        rd(8'h0C, "unmapped_0c", 0, 0);
        rd(8'h80, "unmapped_80", 0, 0);
        wr(8'h0C, 32'hFFFF_FFFF);
        rd(8'h0C, "unmapped_wr", 0, 0);

        // Basic window: 100 cycles, channel 0 period 4
        per[0] = 4;
        repeat (6) @(posedge clk);
        start_window(100, s);
        wait_until(s + 10);
        rd(8'h04, "busy_status", 32'h401, 32'h401);
        check("irq_busy", {31'b0, irq}, 0, 0);
        wait_until(s + 100 + 4);
        check("irq_done", {31'b0, irq}, 1, 1);
        rd(8'h04, "done_status", 32'h402, 32'h402);
        read_counts(100, "win100");
        wr(8'h04, 32'h2);
        check("irq_w1c", {31'b0, irq}, 0, 0);
        rd(8'h04, "w1c_status", 32'h400, 32'h400);
        rd(8'h00, "ctrl_irq_en", 32'h4, 32'h4);

        // Saturation at fclk/2
        per[0] = 0;
        per[1] = 2;
        repeat (6) @(posedge clk);
        start_window(1000, s);
        wait_until(s + 1000 + 4);
        rd(8'h04, "ovf_status", 32'h406, 32'h406);
        read_counts(1000, "sat");

        // Abort after ~10 counting cycles; counts must then stay frozen
        per[0] = 4;
        per[1] = 0;
        repeat (6) @(posedge clk);
        start_window(200, s);
        wait_until(s + 8);
        wr(8'h00, 32'h6);
        a = cyc;
        exp_range(a - s - 1, 4, 2, lo, hi);
        rd(8'h04, "abort_status", 32'h400, 32'h400);
        rd(8'h10, "abort_count0", lo, hi);
        wait_until(a + 60);
        rd(8'h10, "frozen_count0", lo, hi);
        rd(8'h04, "abort_nodone", 32'h400, 32'h400);

        // Second start while busy must not restart the window
        start_window(60, s);
        wait_until(s + 20);
        wr(8'h00, 32'h5);
        wait_until(s + 60 + 4);
        rd(8'h04, "nostart_status", 32'h402, 32'h402);
        read_counts(60, "nostart");

        // Byte lanes, then WINDOW=0 behaving as 1
        wr(8'h08, 32'h1234);
        wr(8'h08, 32'hFFFF_FF05, 4'b0001);
        rd(8'h08, "sel_window", 32'h1205, 32'h1205);
        wr(8'h08, 32'h0);
        wr(8'h00, 32'h5);
        s = cyc;
        wait_until(s + 1 + 4);
        rd(8'h04, "win0_status", 32'h402, 32'h402);

        // Randomised windows and event rates
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < NCH; c++) per[c] = plist[$urandom_range(0, 6)];
            w = int'($urandom_range(20, 200));
            repeat (6) @(posedge clk);
            start_window(w, s);
            wait_until(s + w + 4);
            rd(8'h04, $sformatf("rnd%0d_status", t), 32'h402, 32'h402);
            read_counts(w, $sformatf("rnd%0d", t));
        end

        // Inactive: outputs released, FSM still completes
        per[0] = 4;
        for (int c = 1; c < NCH; c++) per[c] = 0;
        wr(8'h08, 32'd50);
        @(posedge clk);
        #1;
        active = 1'b0;
        quiet_xfer(8'h00, 1'b1, 32'h5);
        s = cyc;
        quiet_xfer(8'h04, 1'b0, '0);
        wait_until(s + 50 + 4);
        check("inactive_irq", {31'b0, irq}, 0, 0);
        active = 1'b1;
        #1;
        check("active_irq", {31'b0, irq}, 1, 1);
        rd(8'h04, "inactive_done", 32'h402, 32'h402);
        read_counts(50, "inactive");

        // Asynchronous reset in the middle of COUNT
        start_window(200, s);
        wait_until(s + 20);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", {31'b0, bus.wbs_ack_o}, 0, 0);
        check("midrst_irq", {31'b0, irq}, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        rd(8'h04, "midrst_status", 32'h400, 32'h400);
        rd(8'h00, "midrst_ctrl", 0, 0);
        rd(8'h08, "midrst_window", 0, 0);
        read_counts(0, "midrst");

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending reads, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500us, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
